// File: rtl/edge_detect_bank.sv
// edge_detect_bank: per-channel sync, debounce, selectable edge pulse, sticky flag and saturating count
module edge_detect_bank #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           din,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]           clr,
  output logic [CHANNELS-1:0]           level,
  output logic [CHANNELS-1:0]           pulse,
  output logic [CHANNELS-1:0]           flag,
  output logic [CNT_WIDTH*CHANNELS-1:0] count,
  output logic                          any_pulse
);
  localparam int DBW = DB_CYCLES > 1 ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sy;
    logic [DBW-1:0] db;
    logic lv, pl, fl, s, acc, hit;
    logic [CNT_WIDTH-1:0] ct;
    assign s   = sy[SYNC_STAGES-1];
    assign acc = (s != lv) && (db == DB_LAST);
    assign hit = acc && (s ? mode[2*i] : mode[2*i+1]);
    // synchronise, debounce, accept new level and record qualifying edges
    always_ff @(posedge clk)
      if (reset) begin
        sy <= '0;
        db <= '0;
        lv <= 1'b0;
        pl <= 1'b0;
        fl <= 1'b0;
        ct <= '0;
      end else begin
        sy <= SYNC_STAGES'({sy, din[i]});
        db <= (s == lv || acc) ? '0 : db + DBW'(1);
        lv <= acc ? s : lv;
        pl <= hit;
        fl <= hit | (fl & ~clr[i]);
        ct <= hit ? (clr[i] ? CNT_WIDTH'(1) : ct + CNT_WIDTH'(~&ct)) : (clr[i] ? '0 : ct);
      end
    assign level[i] = lv;
    assign pulse[i] = pl;
    assign flag[i]  = fl;
    assign count[CNT_WIDTH*i +: CNT_WIDTH] = ct;
  end
  assign any_pulse = |pulse;
endmodule

// File: tb/tb_edge_detect_bank.sv
// tb_edge_detect_bank: table vectors, directed corner sequences and randomized model comparison
module tb_edge_detect_bank;
  localparam int CH = 4, SS = 2, DB = 4, CW = 8;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0, reset;
  logic [CH-1:0] din, clr, level, pulse, flag;
  logic [2*CH-1:0] mode;
  logic [CW*CH-1:0] count;
  logic any_pulse;
  int passed = 0, total = 0;
  bit h [CH][SS+DB];
  bit m_lv [CH], m_pl [CH], m_fl [CH];
  int m_ct [CH];

  edge_detect_bank #(.CHANNELS(CH), .SYNC_STAGES(SS), .DB_CYCLES(DB), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .clr(clr),
    .level(level), .pulse(pulse), .flag(flag), .count(count), .any_pulse(any_pulse)
  );

  always #5 clk = ~clk;

  // a level is accepted once the last DB synchronised samples all differ from it
  function automatic void model_edge();
    for (int c = 0; c < CH; c++) begin
      bit diff, q;
      if (reset) begin
        for (int j = 0; j < SS + DB; j++) h[c][j] = 1'b0;
        m_lv[c] = 0; m_pl[c] = 0; m_fl[c] = 0; m_ct[c] = 0;
      end else begin
        diff = 1'b1;
        for (int j = 0; j < DB; j++) if (h[c][SS-1+j] == m_lv[c]) diff = 1'b0;
        q = diff && (m_lv[c] ? mode[2*c+1] : mode[2*c]);
        m_pl[c] = q;
        m_fl[c] = q || (m_fl[c] && !clr[c]);
        m_ct[c] = q ? (clr[c] ? 1 : (m_ct[c] < CMAX ? m_ct[c] + 1 : CMAX)) : (clr[c] ? 0 : m_ct[c]);
        if (diff) m_lv[c] = !m_lv[c];
        for (int j = SS + DB - 1; j > 0; j--) h[c][j] = h[c][j-1];
        h[c][0] = din[c];
      end
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [CH-1:0] pack_lv();
    logic [CH-1:0] v;
    for (int c = 0; c < CH; c++) v[c] = m_lv[c];
    return v;
  endfunction

  task automatic step();
    logic [CH-1:0] ep, ef;
    model_edge();
    @(posedge clk);
    #1;
    for (int c = 0; c < CH; c++) begin
      ep[c] = m_pl[c];
      ef[c] = m_fl[c];
    end
    check("level", level, pack_lv());
    check("pulse", pulse, ep);
    check("flag", flag, ef);
    check("any_pulse", any_pulse, |ep);
    for (int c = 0; c < CH; c++) check("count", count[c*CW +: CW], m_ct[c]);
  endtask

  typedef struct { bit d; bit c; int n; bit lv; bit pl; bit fl; int ct; } vec_t;
  vec_t tbl [7];

  initial begin
    int npl, at, rises, falls, togs, nap, nall;
    bit prev;
    int modes [4];
    tbl[0] = '{1, 0, 5, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 1, 1, 1, 1};
    tbl[2] = '{1, 0, 1, 1, 0, 1, 1};
    tbl[3] = '{0, 0, 5, 1, 0, 1, 1};
    tbl[4] = '{0, 0, 1, 0, 0, 1, 1};
    tbl[5] = '{0, 1, 1, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 1, 0, 0, 0, 0};
    modes = '{1, 2, 3, 0};
    din = '0; clr = '0; mode = 8'h55; reset = 1'b1;
    step(); step();
    check("reset_out", {level, pulse, flag, any_pulse}, 0);
    check("reset_cnt", count, 0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++)
      for (int r = 0; r < tbl[i].n; r++) begin
        din[0] = tbl[i].d; clr[0] = tbl[i].c;
        step();
        check("tbl_level", level[0], tbl[i].lv);
        check("tbl_pulse", pulse[0], tbl[i].pl);
        check("tbl_flag", flag[0], tbl[i].fl);
        check("tbl_count", count[CW-1:0], tbl[i].ct);
      end
    clr = '0;
    npl = 0; at = -1;
    for (int r = 0; r < 15; r++) begin
      din[1] = (r == 2) ? 1'b0 : 1'b1;
      step();
      if (pulse[1]) begin npl++; at = r; end
    end
    check("bounce_npulse", npl, 1);
    check("bounce_time", at, 8);
    for (int m = 0; m < 4; m++) begin
      mode[5:4] = 2'(modes[m]);
      rises = 0; falls = 0; togs = 0; prev = level[2];
      for (int r = 0; r < 40; r++) begin
        din[2] = (r % 20) < 10;
        step();
        if (pulse[2]) begin if (level[2]) rises++; else falls++; end
        if (level[2] != prev) togs++;
        prev = level[2];
      end
      check("sweep_rises", rises, (modes[m] & 1) ? 2 : 0);
      check("sweep_falls", falls, (modes[m] & 2) ? 2 : 0);
      check("sweep_toggles", togs, 4);
    end
    mode[7:6] = 2'b11;
    for (int e = 0; e < 300; e++) begin
      din[3] = ~din[3];
      repeat (5) step();
    end
    step();
    check("sat_count", count[3*CW +: CW], CMAX);
    din[3] = ~din[3];
    repeat (5) step();
    clr[3] = 1'b1;
    step();
    check("clr_hit_pulse", pulse[3], 1);
    check("clr_hit_flag", flag[3], 1);
    check("clr_hit_count", count[3*CW +: CW], 1);
    clr = '0;
    mode = 8'hFF;
    din = ~pack_lv();
    nap = 0; nall = 0;
    for (int r = 0; r < 10; r++) begin
      step();
      if (any_pulse) nap++;
      if (pulse == 4'hF) nall++;
    end
    check("all_any_pulse", nap, 1);
    check("all_together", nall, 1);
    din[0] = ~din[0];
    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_mid_out", {level, pulse, flag}, 0);
    check("rst_mid_cnt", count, 0);
    din = 4'hF;
    step();
    reset = 1'b0;
    nap = 0; nall = 0; at = -1;
    for (int r = 0; r < 10; r++) begin
      step();
      if (any_pulse) begin nap++; at = r; end
      if (pulse == 4'hF) nall++;
    end
    check("held_npulse", nap, 1);
    check("held_all", nall, 1);
    check("held_time", at, 5);
    for (int r = 0; r < 3000; r++) begin
      for (int c = 0; c < CH; c++) if ($urandom_range(5) == 0) din[c] = ~din[c];
      if ($urandom_range(40) == 0) mode = 8'($urandom);
      for (int c = 0; c < CH; c++) clr[c] = ($urandom_range(15) == 0);
      reset = ($urandom_range(199) == 0);
      step();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
